// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS-style control unit (Moore FSM).
// Sequences FETCH/DECODE and the per-class execution states, and decodes the datapath
// controls from the current state and the opcode latched in DECODE.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   OpCode            - instruction opcode, sampled in DECODE
//   MemReady          - memory access completes this cycle
//   PCWrite..ALUSrcA  - one-bit datapath controls
//   ALUSrcB, PCSource - operand / PC source selects
//   ALUOp             - ALU operation class, 3-bit codes zero-extended to ALUOP_W
//   BranchType        - 00 beq, 01 bne, 10 bgtz
//   State             - current FSM state
//   IllegalOp         - pulse in DECODE for an unknown opcode
//   InstrDone         - pulse in the last cycle of each legal instruction
//   InstrCount        - retired-instruction counter, wraps
module unidad_control_multiciclo #(
   parameter int unsigned ALUOP_W     = 3,
   parameter bit          MEM_WAIT_EN = 1'b1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         OpCode,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemToReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         BranchType,
   output logic [3:0]         State,
   output logic               IllegalOp,
   output logic               InstrDone,
   output logic [CNT_W-1:0]   InstrCount
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StRwb    = 4'd7,
      StIExec  = 4'd8,
      StIwb    = 4'd9,
      StBranch = 4'd10,
      StJump   = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpBgtz  = 6'b000111;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   state_e           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic mem_rdy;
   logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;
   logic illegal_op, instr_done;
   logic [2:0] alu_op3;

   // With waiting disabled every memory access completes in one cycle.
   assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

   // Next-state and opcode latch.
   always_comb begin
      state_d = StFetch;
      op_d    = op_q;
      case (state_q)
         StFetch:  state_d = mem_rdy ? StDecode : StFetch;
         StDecode: begin
            op_d = OpCode;
            case (OpCode)
               OpLw, OpSw:                   state_d = StMemAdr;
               OpRtype:                      state_d = StExec;
               OpAddi, OpAndi, OpOri, OpSlti: state_d = StIExec;
               OpBeq, OpBne, OpBgtz:         state_d = StBranch;
               OpJ:                          state_d = StJump;
               default:                      state_d = StFetch;
            endcase
         end
         StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
         StMemRd:  state_d = mem_rdy ? StMemWb : StMemRd;
         StMemWb:  state_d = StFetch;
         StMemWr:  state_d = mem_rdy ? StFetch : StMemWr;
         StExec:   state_d = StRwb;
         StRwb:    state_d = StFetch;
         StIExec:  state_d = StIwb;
         StIwb:    state_d = StFetch;
         StBranch: state_d = StFetch;
         StJump:   state_d = StFetch;
         default:  state_d = StFetch;
      endcase
   end

   assign cnt_d = instr_done ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         op_q    <= 6'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output decode from state and latched opcode; only FETCH/MEMWR look at MemReady and
   // DECODE looks at the live opcode (the latched copy is not yet valid there).
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      IorD          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      MemToReg      = 1'b0;
      RegDst        = 1'b0;
      reg_write     = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 2'b00;
      alu_op3       = 3'b000;
      BranchType    = 2'b00;
      illegal_op    = 1'b0;
      instr_done    = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read = 1'b1;
            ALUSrcB  = 2'b01;
            ir_write = mem_rdy;
            pc_write = mem_rdy;
         end
         StDecode: begin
            ALUSrcB = 2'b11;
            case (OpCode)
               OpLw, OpSw, OpRtype, OpAddi, OpAndi, OpOri, OpSlti,
               OpBeq, OpBne, OpBgtz, OpJ: illegal_op = 1'b0;
               default:                   illegal_op = 1'b1;
            endcase
         end
         StMemAdr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StMemRd: begin
            mem_read = 1'b1;
            IorD     = 1'b1;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            MemToReg   = 1'b1;
            instr_done = 1'b1;
         end
         StMemWr: begin
            mem_write  = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_rdy;
         end
         StExec: begin
            ALUSrcA = 1'b1;
            alu_op3 = 3'b010;
         end
         StRwb: begin
            RegDst     = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         StIExec: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (op_q)
               OpAndi:  alu_op3 = 3'b100;
               OpOri:   alu_op3 = 3'b101;
               OpSlti:  alu_op3 = 3'b111;
               default: alu_op3 = 3'b000;
            endcase
         end
         StIwb: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         StBranch: begin
            ALUSrcA       = 1'b1;
            pc_write_cond = 1'b1;
            PCSource      = 2'b01;
            instr_done    = 1'b1;
            case (op_q)
               OpBne: begin
                  alu_op3    = 3'b001;
                  BranchType = 2'b01;
               end
               OpBgtz: begin
                  alu_op3    = 3'b110;
                  BranchType = 2'b10;
               end
               default: begin
                  alu_op3    = 3'b001;
                  BranchType = 2'b00;
               end
            endcase
         end
         StJump: begin
            pc_write   = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   // State-changing strobes are forced low while reset is held.
   assign PCWrite     = pc_write & ~reset;
   assign PCWriteCond = pc_write_cond & ~reset;
   assign MemRead     = mem_read & ~reset;
   assign MemWrite    = mem_write & ~reset;
   assign IRWrite     = ir_write & ~reset;
   assign RegWrite    = reg_write & ~reset;
   assign IllegalOp   = illegal_op & ~reset;
   assign InstrDone   = instr_done & ~reset;

   assign ALUOp      = ALUOP_W'(alu_op3);
   assign State      = state_q;
   assign InstrCount = cnt_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
module tb_unidad_control_multiciclo;

   typedef struct packed {
      logic [3:0]  st;
      logic [9:0]  ctl;
      logic [1:0]  srcb;
      logic [1:0]  pcsrc;
      logic [4:0]  aluop;
      logic [1:0]  bt;
      logic        ill;
      logic        done;
      logic [15:0] cnt;
   } exp_t;

   // ctl bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite ALUSrcA
   localparam logic [9:0] PCW  = 10'b1000000000;
   localparam logic [9:0] PCC  = 10'b0100000000;
   localparam logic [9:0] IORD = 10'b0010000000;
   localparam logic [9:0] MRD  = 10'b0001000000;
   localparam logic [9:0] MWR  = 10'b0000100000;
   localparam logic [9:0] IRW  = 10'b0000010000;
   localparam logic [9:0] M2R  = 10'b0000001000;
   localparam logic [9:0] RDST = 10'b0000000100;
   localparam logic [9:0] RW   = 10'b0000000010;
   localparam logic [9:0] SRCA = 10'b0000000001;
   localparam logic [9:0] FET  = PCW | MRD | IRW;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, J = 6'b000010;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGTZ = 6'b000111;
   localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, BAD = 6'b111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 1: default parameters
   logic reset, MemReady;
   logic [5:0] OpCode;
   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite;
   logic ALUSrcA, IllegalOp, InstrDone;
   logic [1:0] ALUSrcB, PCSource, BranchType;
   logic [2:0] ALUOp;
   logic [3:0] State;
   logic [15:0] InstrCount;

   // DUT 2: narrow counter, wide ALUOp
   logic rst2, mr2;
   logic [5:0] op2;
   logic pcw2, pcc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, srca2, ill2, done2;
   logic [1:0] srcb2, pcsrc2, bt2;
   logic [4:0] aluop2;
   logic [3:0] st2;
   logic [1:0] cnt2;

   unidad_control_multiciclo dut (
      .clk(clk), .reset(reset), .OpCode(OpCode), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUOp(ALUOp), .BranchType(BranchType), .State(State), .IllegalOp(IllegalOp),
      .InstrDone(InstrDone), .InstrCount(InstrCount)
   );

   unidad_control_multiciclo #(.ALUOP_W(5), .MEM_WAIT_EN(1'b1), .CNT_W(2)) dut2 (
      .clk(clk), .reset(rst2), .OpCode(op2), .MemReady(mr2),
      .PCWrite(pcw2), .PCWriteCond(pcc2), .IorD(iord2), .MemRead(mrd2),
      .MemWrite(mwr2), .IRWrite(irw2), .MemToReg(m2r2), .RegDst(rdst2),
      .RegWrite(rw2), .ALUSrcA(srca2), .ALUSrcB(srcb2), .PCSource(pcsrc2),
      .ALUOp(aluop2), .BranchType(bt2), .State(st2), .IllegalOp(ill2),
      .InstrDone(done2), .InstrCount(cnt2)
   );

   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int n = 0;

   function automatic exp_t mk(input logic [3:0] st, input logic [9:0] ctl,
                               input logic [1:0] srcb, input logic [1:0] pcsrc,
                               input logic [4:0] aluop, input logic [1:0] bt,
                               input logic ill, input logic done, input logic [15:0] cnt);
      exp_t e;
      e.st = st; e.ctl = ctl; e.srcb = srcb; e.pcsrc = pcsrc; e.aluop = aluop;
      e.bt = bt; e.ill = ill; e.done = done; e.cnt = cnt;
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL step %0d %s: got %0h want %0h", n, tag, obs, exp);
      end
   endtask

   task automatic check(input bit sel);
      exp_t e;
      exp_t o;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL step %0d scoreboard: got empty want entry", n);
      end else begin
         e = sb.pop_front();
         if (!sel) o = mk(State, {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                              MemToReg, RegDst, RegWrite, ALUSrcA}, ALUSrcB, PCSource,
                              {2'b00, ALUOp}, BranchType, IllegalOp, InstrDone, InstrCount);
         else      o = mk(st2, {pcw2, pcc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, srca2},
                              srcb2, pcsrc2, aluop2, bt2, ill2, done2, {14'd0, cnt2});
         cmp("state", 16'(o.st), 16'(e.st));
         cmp("ctl", 16'(o.ctl), 16'(e.ctl));
         cmp("alusrcb", 16'(o.srcb), 16'(e.srcb));
         cmp("pcsource", 16'(o.pcsrc), 16'(e.pcsrc));
         cmp("aluop", 16'(o.aluop), 16'(e.aluop));
         cmp("branchtype", 16'(o.bt), 16'(e.bt));
         cmp("illegalop", 16'(o.ill), 16'(e.ill));
         cmp("instrdone", 16'(o.done), 16'(e.done));
         cmp("instrcount", o.cnt, e.cnt);
      end
   endtask

   // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
   task automatic s(input bit sel, input logic [5:0] op, input logic mr, input logic rst,
                    input exp_t e);
      if (!sel) begin
         OpCode = op; MemReady = mr; reset = rst;
      end else begin
         op2 = op; mr2 = mr; rst2 = rst;
      end
      sb.push_back(e);
      @(negedge clk);
      check(sel);
      @(posedge clk);
      #1;
      n++;
   endtask

   initial begin
      reset = 1'b1; MemReady = 1'b1; OpCode = 6'd0;
      rst2 = 1'b1; mr2 = 1'b1; op2 = 6'd0;
      repeat (2) @(posedge clk);
      #1;

      // reset state, strobes gated while reset high
      s(0, RT, 1, 1, mk(0, 10'd0, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 0));

      // lw, no waits; opcode changes after DECODE must not matter
      s(0, LW, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 0));
      s(0, LW, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 0));
      s(0, SW, 1, 0, mk(2, SRCA, 2'b10, 2'b00, 5'd0, 2'b00, 0, 0, 0));
      s(0, RT, 1, 0, mk(3, MRD | IORD, 2'b00, 2'b00, 5'd0, 2'b00, 0, 0, 0));
      s(0, BAD, 1, 0, mk(4, RW | M2R, 2'b00, 2'b00, 5'd0, 2'b00, 0, 1, 0));

      // sw with a fetch wait and three write waits
      s(0, RT, 0, 0, mk(0, MRD, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 1));
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 1));
      s(0, SW, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 1));
      s(0, SW, 1, 0, mk(2, SRCA, 2'b10, 2'b00, 5'd0, 2'b00, 0, 0, 1));
      for (int i = 0; i < 3; i++)
         s(0, SW, 0, 0, mk(5, MWR | IORD, 2'b00, 2'b00, 5'd0, 2'b00, 0, 0, 1));
      s(0, SW, 1, 0, mk(5, MWR | IORD, 2'b00, 2'b00, 5'd0, 2'b00, 0, 1, 1));

      // R-type
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 2));
      s(0, RT, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 2));
      s(0, ANDI, 1, 0, mk(6, SRCA, 2'b00, 2'b00, 5'b00010, 2'b00, 0, 0, 2));
      s(0, RT, 1, 0, mk(7, RDST | RW, 2'b00, 2'b00, 5'd0, 2'b00, 0, 1, 2));

      // andi
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 3));
      s(0, ANDI, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 3));
      s(0, ORI, 1, 0, mk(8, SRCA, 2'b10, 2'b00, 5'b00100, 2'b00, 0, 0, 3));
      s(0, RT, 1, 0, mk(9, RW, 2'b00, 2'b00, 5'd0, 2'b00, 0, 1, 3));

      // beq, bgtz, bne
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 4));
      s(0, BEQ, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 4));
      s(0, BGTZ, 1, 0, mk(10, SRCA | PCC, 2'b00, 2'b01, 5'b00001, 2'b00, 0, 1, 4));
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 5));
      s(0, BGTZ, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 5));
      s(0, BEQ, 1, 0, mk(10, SRCA | PCC, 2'b00, 2'b01, 5'b00110, 2'b10, 0, 1, 5));
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 6));
      s(0, BNE, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 6));
      s(0, RT, 1, 0, mk(10, SRCA | PCC, 2'b00, 2'b01, 5'b00001, 2'b01, 0, 1, 6));

      // illegal opcode: one-cycle pulse, back to FETCH, count unchanged
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 7));
      s(0, BAD, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 1, 0, 7));
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 7));

      // jump
      s(0, J, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 7));
      s(0, RT, 1, 0, mk(11, PCW, 2'b00, 2'b10, 5'd0, 2'b00, 0, 1, 7));

      // reset during a MEMRD wait
      s(0, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 8));
      s(0, LW, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 8));
      s(0, LW, 1, 0, mk(2, SRCA, 2'b10, 2'b00, 5'd0, 2'b00, 0, 0, 8));
      s(0, LW, 0, 0, mk(3, MRD | IORD, 2'b00, 2'b00, 5'd0, 2'b00, 0, 0, 8));
      s(0, LW, 0, 1, mk(3, IORD, 2'b00, 2'b00, 5'd0, 2'b00, 0, 0, 8));
      s(0, LW, 0, 1, mk(0, 10'd0, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 0));
      s(0, LW, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 0));
      reset = 1'b1;

      // narrow counter wraps, wide ALUOp zero-extends
      s(1, RT, 1, 1, mk(0, 10'd0, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 0));
      for (int j = 0; j < 5; j++) begin
         s(1, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 16'(j % 4)));
         s(1, J, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 16'(j % 4)));
         s(1, RT, 1, 0, mk(11, PCW, 2'b00, 2'b10, 5'd0, 2'b00, 0, 1, 16'(j % 4)));
      end
      s(1, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 1));
      s(1, ORI, 1, 0, mk(1, 10'd0, 2'b11, 2'b00, 5'd0, 2'b00, 0, 0, 1));
      s(1, RT, 1, 0, mk(8, SRCA, 2'b10, 2'b00, 5'b00101, 2'b00, 0, 0, 1));
      s(1, RT, 1, 0, mk(9, RW, 2'b00, 2'b00, 5'd0, 2'b00, 0, 1, 1));
      s(1, RT, 1, 0, mk(0, FET, 2'b01, 2'b00, 5'd0, 2'b00, 0, 0, 2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
